window3x3_gen: RTL and testbench

WINDOW3X3_GEN -- requirements
Module: window3x3_gen

---
 rtl/cnn_pkg.sv | 26 ++
 rtl/line_buffer.sv | 26 ++
 rtl/window3x3_gen.sv | 131 +++++++++++++
 tb/tb_window3x3_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Definitions shared by the CNN front end: the default pixel width, the signed
// pixel type and the 3x3 window index map, which the pooling stage also uses.
package cnn_pkg;

  localparam int CNN_DATA_W = 16;

  typedef logic signed [CNN_DATA_W-1:0] pix_t;

  // Window positions, row-major; row 0 is the oldest image row.
  localparam int WIN_N  = 9;
  localparam int WIN_TL = 0;
  localparam int WIN_TC = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_MC = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BC = 7;
  localparam int WIN_BR = 8;

  // Flat window index from (window row, window column).
  function automatic int win_idx(input int r, input int c);
    return r * 3 + c;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of storage. Reads are combinational, so a pixel can be read and
// replaced at the same column in a single cycle. Contents are not reset.
module line_buffer
  import cnn_pkg::*;
#(
  parameter int DEPTH  = 28,
  parameter int DATA_W = CNN_DATA_W,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [AW-1:0]            i_addr,
  input  logic signed [DATA_W-1:0] i_wdata,
  output logic signed [DATA_W-1:0] o_rdata
);

  logic signed [DATA_W-1:0] r_mem [DEPTH];

  // Write the incoming value at the addressed column when enabled.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/window3x3_gen.sv
// 3x3 sliding-window generator over a raster pixel stream.
// Two line buffers keep the previous two rows; a 3x3 register array shifts in
// one column {row-2, row-1, current} per accepted pixel. A window is flagged one
// cycle after the pixel that completes it (row>=2, col>=2); no padding.
// Optional build macro: WINGEN_STRIDE2_EN -- only windows completed at even row
// and even column are flagged (IMG_W and IMG_H must be odd).
// Handshake: valid_in qualifies pix_in for one cycle and there is no
// backpressure; valid_out qualifies win0..win8 for exactly one cycle.
module window3x3_gen
  import cnn_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = CNN_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] pix_in,
  output logic signed [DATA_W-1:0] win0,
  output logic signed [DATA_W-1:0] win1,
  output logic signed [DATA_W-1:0] win2,
  output logic signed [DATA_W-1:0] win3,
  output logic signed [DATA_W-1:0] win4,
  output logic signed [DATA_W-1:0] win5,
  output logic signed [DATA_W-1:0] win6,
  output logic signed [DATA_W-1:0] win7,
  output logic signed [DATA_W-1:0] win8,
  output logic                     valid_out,
  output logic                     frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]            r_col;
  logic [RW-1:0]            r_row;
  logic signed [DATA_W-1:0] r_win [WIN_N];
  logic                     r_valid_out;
  logic                     r_frame_done;

  logic signed [DATA_W-1:0] w_row1;   // pixel one row above, same column
  logic signed [DATA_W-1:0] w_row2;   // pixel two rows above, same column
  logic                     w_col_last;
  logic                     w_row_last;
  logic                     w_win_done;

  // Row-1 buffer takes the new pixel; row-2 buffer takes what row-1 held there.
  line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W), .AW(CW)) u_lb_row1 (
    .clk     (clk),
    .i_we    (valid_in),
    .i_addr  (r_col),
    .i_wdata (pix_in),
    .o_rdata (w_row1)
  );

  line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W), .AW(CW)) u_lb_row2 (
    .clk     (clk),
    .i_we    (valid_in),
    .i_addr  (r_col),
    .i_wdata (w_row1),
    .o_rdata (w_row2)
  );

  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);

  // Decide whether the pixel being accepted completes a reportable window.
  always_comb begin
    w_win_done = valid_in && (r_row >= RW'(2)) && (r_col >= CW'(2));
`ifdef WINGEN_STRIDE2_EN
    w_win_done = w_win_done && !r_row[0] && !r_col[0];
`endif
  end

  // Raster position of the next pixel; both counters wrap at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (valid_in) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Shift the window left one column and load the new column on the right.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_N; i++) r_win[i] <= '0;
    end else if (valid_in) begin
      for (int r = 0; r < 3; r++) begin
        r_win[win_idx(r, 0)] <= r_win[win_idx(r, 1)];
        r_win[win_idx(r, 1)] <= r_win[win_idx(r, 2)];
      end
      r_win[WIN_TR] <= w_row2;
      r_win[WIN_MR] <= w_row1;
      r_win[WIN_BR] <= pix_in;
    end
  end

  // Window-valid and end-of-frame flags, one cycle after the completing pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid_out  <= w_win_done;
      r_frame_done <= w_win_done && w_col_last && w_row_last;
    end
  end

  assign win0       = r_win[WIN_TL];
  assign win1       = r_win[WIN_TC];
  assign win2       = r_win[WIN_TR];
  assign win3       = r_win[WIN_ML];
  assign win4       = r_win[WIN_MC];
  assign win5       = r_win[WIN_MR];
  assign win6       = r_win[WIN_BL];
  assign win7       = r_win[WIN_BC];
  assign win8       = r_win[WIN_BR];
  assign valid_out  = r_valid_out;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_window3x3_gen.sv
// Bench for window3x3_gen on a 5x5 image. The reference model stores each frame
// as a flat array indexed by pixel number and cuts expected windows out of it.
module tb_window3x3_gen;

  localparam int W   = 5;
  localparam int H   = 5;
  localparam int DW  = 16;
  localparam int CMW = 9 * DW;
`ifdef WINGEN_STRIDE2_EN
  localparam int WPF = ((W - 1) / 2) * ((H - 1) / 2);
`else
  localparam int WPF = (W - 2) * (H - 2);
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 valid_in;
  logic signed [DW-1:0] pix_in;
  logic signed [DW-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
  logic                 valid_out;
  logic                 frame_done;

  window3x3_gen #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .pix_in     (pix_in),
    .win0       (win0),
    .win1       (win1),
    .win2       (win2),
    .win3       (win3),
    .win4       (win4),
    .win5       (win5),
    .win6       (win6),
    .win7       (win7),
    .win8       (win8),
    .valid_out  (valid_out),
    .frame_done (frame_done)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [CMW-1:0] exp_q[$];
  int             img [W*H];
  int             pix_n;        // index of next pixel within the frame
  int             vectors;
  int             miscompares;
  int             wins_seen;
  logic [CMW-1:0] first_win;
  logic           first_seen;

  function automatic logic [CMW-1:0] dut_window();
    return {win0, win1, win2, win3, win4, win5, win6, win7, win8};
  endfunction

  function automatic logic [CMW-1:0] pack9(input int v [9]);
    logic [CMW-1:0] pk;
    logic [DW-1:0]  e;
    pk = '0;
    for (int i = 0; i < 9; i++) begin
      e = v[i][DW-1:0];
      pk[(8-i)*DW +: DW] = e;
    end
    return pk;
  endfunction

  task automatic check(input string tag, input logic [CMW-1:0] got,
                       input logic [CMW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Drop all model state as a reset does.
  task automatic model_reset();
    pix_n = 0;
    exp_q.delete();
  endtask

  // Drive one cycle, update the model from the spec rules, check outputs.
  task automatic apply(input bit v, input int p);
    int       r, c;
    bit       exp_v, exp_fd;
    int       vals [9];
    logic [CMW-1:0] pk;
    valid_in = v;
    pix_in   = p[DW-1:0];
    @(posedge clk);
    exp_v  = 1'b0;
    exp_fd = 1'b0;
    if (v) begin
      img[pix_n] = p;
      r = pix_n / W;
      c = pix_n % W;
`ifdef WINGEN_STRIDE2_EN
      exp_v = (r >= 2) && (c >= 2) && (r % 2 == 0) && (c % 2 == 0);
`else
      exp_v = (r >= 2) && (c >= 2);
`endif
      if (exp_v) begin
        for (int i = 0; i < 9; i++)
          vals[i] = img[(r - 2 + i / 3) * W + (c - 2 + i % 3)];
        exp_q.push_back(pack9(vals));
        exp_fd = (pix_n == W * H - 1);
      end
      pix_n = (pix_n == W * H - 1) ? 0 : pix_n + 1;
    end
    @(negedge clk);
    check("valid_out", {{(CMW-1){1'b0}}, valid_out}, {{(CMW-1){1'b0}}, exp_v});
    check("frame_done", {{(CMW-1){1'b0}}, frame_done}, {{(CMW-1){1'b0}}, exp_fd});
    if (exp_v) begin
      pk = exp_q.pop_front();
      if (valid_out) check("window", dut_window(), pk);
    end
    if (valid_out) begin
      wins_seen++;
      if (!first_seen) begin
        first_win  = dut_window();
        first_seen = 1'b1;
      end
    end
  endtask

  // Drive a frame of consecutive values; gap_mode 0 none, 1 alternate, 2 random.
  task automatic drive_frame(input int base, input int gap_mode);
    for (int k = 0; k < W * H; k++) begin
      if (gap_mode == 1) apply(1'b0, 0);
      else if (gap_mode == 2 && $urandom_range(0, 2) == 0) apply(1'b0, $urandom);
      apply(1'b1, base + k);
    end
    apply(1'b0, 0);
  endtask

  task automatic drive_random_frame();
    for (int k = 0; k < W * H; k++) begin
      if ($urandom_range(0, 3) == 0) apply(1'b0, 0);
      apply(1'b1, int'($urandom_range(0, 65535)) - 32768);
    end
    apply(1'b0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {{(CMW-1){1'b0}}, valid_out}, '0);
    check({tag, "_fdone"}, {{(CMW-1){1'b0}}, frame_done}, '0);
    check({tag, "_win"}, dut_window(), '0);
  endtask

  task automatic start_count();
    wins_seen  = 0;
    first_seen = 1'b0;
  endtask

  function automatic logic [CMW-1:0] lin_win(input int a);
    int v [9];
    for (int i = 0; i < 9; i++) v[i] = a + (i / 3) * W + (i % 3);
    return pack9(v);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    valid_in    = 1'b0;
    pix_in      = '0;
    model_reset();
    #1;
    check_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Continuous frame 0..24.
    start_count();
    drive_frame(0, 0);
    check("f1_count", CMW'(wins_seen), CMW'(WPF));
`ifdef WINGEN_STRIDE2_EN
    check("f1_first", first_win, lin_win(0));
`else
    check("f1_first", first_win, lin_win(0));
`endif

    // Same frame, idle every other cycle.
    start_count();
    drive_frame(0, 1);
    check("gap_count", CMW'(wins_seen), CMW'(WPF));

    // Two back-to-back frames.
    start_count();
    for (int k = 0; k < W * H; k++) apply(1'b1, k);
    for (int k = 0; k < W * H; k++) begin
      apply(1'b1, 100 + k);
      if (k == 0) first_seen = 1'b0;
    end
    apply(1'b0, 0);
    check("b2b_count", CMW'(wins_seen), CMW'(2 * WPF));
    check("b2b_first2", first_win, lin_win(100));

    // Reset after pixel 15, then a fresh frame.
    for (int k = 0; k <= 15; k++) apply(1'b1, 500 + k);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    start_count();
    drive_frame(0, 0);
    check("rst_count", CMW'(wins_seen), CMW'(WPF));
    check("rst_first", first_win, lin_win(0));

    // Signed pixels -12..12.
    start_count();
    drive_frame(-12, 0);
    check("signed_first", first_win, lin_win(-12));

    // Random pixel values with random idle cycles.
    for (int f = 0; f < 4; f++) begin
      start_count();
      drive_random_frame();
      check("rand_count", CMW'(wins_seen), CMW'(WPF));
    end
    start_count();
    drive_frame(1000, 2);
    check("randgap_count", CMW'(wins_seen), CMW'(WPF));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
